// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package wrr_burst_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int NUM_REQ_DEF = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(NUM_REQ_DEF);

    // A programmed weight of zero still grants one burst per turn.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/wrr_burst_arbiter_if.sv
// Requester-side and downstream valid/ready/last stream signals of the arbiter.
interface wrr_burst_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic                      out_ready;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/wrr_burst_arbiter_rr_onehot_pick.sv
// Combinational round-robin search: lowest request at or above a one-hot base, wrapping.
module rr_onehot_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] base,
    output logic [N-1:0] winner
);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    // Subtracting the base clears everything below it in the lower copy; the upper copy covers the wrap.
    always_comb begin
        dbl    = {req, req};
        masked = dbl & ~(dbl - {{N{1'b0}}, base});
        winner = masked[N-1:0] | masked[2*N-1:N];
    end
endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter that grants the shared output stream for whole bursts.
module wrr_burst_arbiter
    import wrr_burst_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int WGT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    wrr_burst_arbiter_if.slave       bus,
    input  logic [NUM_REQ*WGT_W-1:0] weight,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy
);
    localparam int IW = idx_width(NUM_REQ);

    state_t             state;
    logic [NUM_REQ-1:0] ptr;
    logic [NUM_REQ-1:0] pick;
    logic [WGT_W-1:0]   cnt;
    logic [WGT_W-1:0]   n_next;
    logic [WGT_W-1:0]   owner_wgt;
    logic [IW-1:0]      owner_idx;
    logic [IW-1:0]      prev_idx;
    logic               prev_vld;
    logic               burst_done;
    logic               quota_met;

    rr_onehot_pick #(.N(NUM_REQ)) u_pick (
        .req    (bus.req_valid),
        .base   (ptr),
        .winner (pick)
    );

    // Pass-through mux for the owner; reset blanks the handshake so no beat can move that cycle.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.req_ready = '0;
        owner_idx     = '0;
        owner_wgt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                owner_idx        = IW'(i);
                owner_wgt        = weight[i*WGT_W +: WGT_W];
                bus.out_valid    = bus.req_valid[i] && !rst;
                bus.out_data     = bus.req_data[i*DATA_W +: DATA_W];
                bus.out_last     = bus.req_last[i];
                bus.req_ready[i] = bus.out_ready && !rst;
            end
        end
    end

    always_comb begin
        burst_done = bus.out_valid && bus.out_ready && bus.out_last;
        n_next     = (prev_vld && (prev_idx == owner_idx)) ? cnt + 1'b1 : WGT_W'(1);
        quota_met  = 32'(n_next) >= eff_weight(32'(owner_wgt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            ptr      <= NUM_REQ'(1);
            cnt      <= '0;
            prev_idx <= '0;
            prev_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gnt   <= pick;
                        busy  <= 1'b1;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (burst_done) begin
                        // Quota used up: move the base just past the owner, otherwise park it on the owner.
                        if (quota_met) begin
                            ptr <= {gnt[NUM_REQ-2:0], gnt[NUM_REQ-1]};
                            cnt <= '0;
                        end else begin
                            ptr <= gnt;
                            cnt <= n_next;
                        end
                        prev_idx <= owner_idx;
                        prev_vld <= 1'b1;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: table of arbitration scenarios plus hand-written corner sequences.
module tb_wrr_burst_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 4;

    typedef struct packed {
        logic [N-1:0]    mask;
        logic [N*WW-1:0] wgt;
        logic [15:0]     order;
    } scen_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    gnt;
    logic            busy;

    int    checks = 0;
    int    errors = 0;
    int    beat [N];
    int    burst_no [N];
    scen_t tbl [5];

    wrr_burst_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    wrr_burst_arbiter #(.NUM_REQ(N), .DATA_W(DW), .WGT_W(WW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .weight (weight),
        .gnt    (gnt),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] ord(input int a, input int b = 0, input int c = 0, input int d = 0,
                                        input int e = 0, input int f = 0, input int g = 0, input int h = 0);
        return {2'(h), 2'(g), 2'(f), 2'(e), 2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    function automatic logic [31:0] model_data(input int i, input int bt, input int bn);
        return {8'(i), 8'(bn), 8'h5A, 8'(bt)};
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            beat[i]     = 0;
            burst_no[i] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] mask, input int nbeats);
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = mask[i];
            bus.req_last[i]           = (beat[i] == nbeats - 1);
            bus.req_data[i*DW +: DW]  = model_data(i, beat[i], burst_no[i]);
        end
    endtask

    // Check the muxed outputs against the requester model, then advance beats that hand-shook.
    task automatic observe(input int nbeats, output bit last_xfer);
        int k;
        last_xfer = 1'b0;
        check_output("ready_owner_only", 32'(bus.req_ready & ~gnt), 32'd0);
        k = oh_idx(gnt);
        if (k < 0) begin
            check_output("idle_out_valid", 32'(bus.out_valid), 32'd0);
        end else if (bus.out_valid) begin
            check_output("out_data", bus.out_data, model_data(k, beat[k], burst_no[k]));
            check_output("out_last", 32'(bus.out_last), 32'(beat[k] == nbeats - 1));
        end
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                if (beat[i] == nbeats - 1) begin
                    beat[i] = 0;
                    burst_no[i]++;
                    last_xfer = 1'b1;
                end else begin
                    beat[i]++;
                end
            end
        end
    endtask

    task automatic run_bursts(input logic [N-1:0] mask, input logic [15:0] order, input int count,
                              input int nbeats, input string tag);
        int           got    = 0;
        bit           bubble = 1'b0;
        bit           last_seen;
        logic [N-1:0] prev   = '0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (bubble) begin
                check_output({tag, " idle_bubble"}, 32'(gnt), 32'd0);
                bubble = 1'b0;
                if (got == count) begin
                    bus.req_valid = '0;
                    return;
                end
            end
            if (gnt != '0 && prev == '0) begin
                if (got < count)
                    check_output($sformatf("%s grant%0d", tag, got), 32'(gnt), 32'd1 << order[got*2 +: 2]);
                got++;
            end
            prev = gnt;
            apply_stimulus(mask, nbeats);
            #1;
            observe(nbeats, last_seen);
            if (last_seen) bubble = 1'b1;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout: got %0d grants, expected %0d", tag, got, count);
        bus.req_valid = '0;
    endtask

    initial begin
        logic [31:0] bp_data [4];
        int          b;
        int          cur;
        int          stall;
        int          gap;
        int          cyc;

        tbl[0] = '{mask: 4'b1111, wgt: 16'h1111, order: ord(0, 1, 2, 3, 0, 1, 2, 3)};
        tbl[1] = '{mask: 4'b1001, wgt: 16'h3111, order: ord(0, 3, 3, 3, 0, 3, 3, 3)};
        tbl[2] = '{mask: 4'b0110, wgt: 16'h1101, order: ord(1, 2, 1, 2, 1, 2, 1, 2)};
        tbl[3] = '{mask: 4'b1111, wgt: 16'h1211, order: ord(0, 1, 2, 2, 3, 0, 1, 2)};
        tbl[4] = '{mask: 4'b1010, wgt: 16'h2222, order: ord(1, 1, 3, 3, 1, 1, 3, 3)};

        // Reset state with every requester already asking, then first-grant latency.
        rst    = 1'b1;
        weight = 16'h1111;
        for (int i = 0; i < N; i++) begin
            beat[i]     = 0;
            burst_no[i] = 0;
        end
        bus.out_ready = 1'b1;
        apply_stimulus(4'b1111, 2);
        @(negedge clk);
        #1;
        check_output("reset gnt", 32'(gnt), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_output("first gnt", 32'(gnt), 32'h1);
        check_output("first busy", 32'(busy), 32'd1);
        check_output("first out_valid", 32'(bus.out_valid), 32'd1);
        check_output("first out_data", bus.out_data, model_data(0, 0, 0));
        check_output("first req_ready", 32'(bus.req_ready), 32'h1);

        for (int s = 0; s < 5; s++) begin
            do_reset();
            weight = tbl[s].wgt;
            run_bursts(tbl[s].mask, tbl[s].order, 8, 2, $sformatf("scen%0d", s));
        end

        // Backpressure at beat B and a valid gap before beat C from owner 2.
        do_reset();
        weight     = 16'h1111;
        bp_data[0] = 32'hAAAA_0001;
        bp_data[1] = 32'hBBBB_0002;
        bp_data[2] = 32'hCCCC_0003;
        bp_data[3] = 32'hDDDD_0004;
        b     = 0;
        stall = 3;
        gap   = 2;
        cyc   = 0;
        while (b < 4 && cyc < 40) begin
            @(negedge clk);
            cur                      = b;
            bus.req_valid            = (cur == 2 && gap > 0) ? 4'b0000 : 4'b0100;
            bus.req_data             = '0;
            bus.req_data[2*DW +: DW] = bp_data[cur];
            bus.req_last             = (cur == 3) ? 4'b0100 : 4'b0000;
            bus.out_ready            = !(cur == 1 && stall > 0);
            #1;
            if (cyc > 0) check_output("bp gnt", 32'(gnt), 32'h4);
            check_output("bp other ready", 32'(bus.req_ready & 4'b1011), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                check_output($sformatf("bp beat%0d", cur), bus.out_data, bp_data[cur]);
                b++;
            end else if (cur == 1 && stall > 0) begin
                check_output("bp hold valid", 32'(bus.out_valid), 32'd1);
                check_output("bp hold data", bus.out_data, bp_data[1]);
            end else if (cur == 2 && gap > 0) begin
                check_output("bp gap valid", 32'(bus.out_valid), 32'd0);
            end
            if (cur == 1 && stall > 0) stall--;
            if (cur == 2 && gap > 0) gap--;
            cyc++;
        end
        check_output("bp beats delivered", 32'(b), 32'd4);
        @(negedge clk);
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        #1;
        check_output("bp end gnt", 32'(gnt), 32'd0);
        check_output("bp end busy", 32'(busy), 32'd0);

        // Parked pointer on an absent requester: the next one in rotation wins with a fresh count.
        do_reset();
        weight = 16'h1112;
        run_bursts(4'b0001, ord(0), 1, 1, "skip_a r0");
        run_bursts(4'b0010, ord(1), 1, 1, "skip_a r1");
        run_bursts(4'b0111, ord(2), 1, 1, "skip_a next");
        do_reset();
        weight = 16'h1122;
        run_bursts(4'b0001, ord(0), 1, 1, "skip_b r0");
        run_bursts(4'b0010, ord(1), 1, 1, "skip_b r1");
        run_bursts(4'b0111, ord(1, 2), 2, 1, "skip_b next");

        // Reset asserted while owner 1 presents its second beat.
        do_reset();
        weight = 16'h1111;
        run_bursts(4'b0001, ord(0), 1, 2, "rst_pre");
        b   = 0;
        cyc = 0;
        while (b < 1 && cyc < 20) begin
            @(negedge clk);
            bus.req_valid             = 4'b0010;
            bus.req_data              = '0;
            bus.req_data[1*DW +: DW]  = 32'h1000_0000;
            bus.req_last              = '0;
            bus.out_ready             = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                check_output("rst owner", 32'(gnt), 32'h2);
                b++;
            end
            cyc++;
        end
        check_output("rst first beat sent", 32'(b), 32'd1);
        @(negedge clk);
        rst                      = 1'b1;
        bus.req_data[1*DW +: DW] = 32'h1000_0001;
        #1;
        check_output("rst cycle out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst cycle req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        check_output("post-rst gnt", 32'(gnt), 32'd0);
        check_output("post-rst busy", 32'(busy), 32'd0);
        check_output("post-rst out_valid", 32'(bus.out_valid), 32'd0);
        check_output("post-rst req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check_output("post-rst winner", 32'(gnt), 32'h1);
        bus.req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
